hilo_ctrl: RTL and testbench
============================

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 33, the number of cycles md_start is held high before the result is captured.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (reset=0 asserts).
REQ-004 SHALL have port op_start  in  1  request to start an operation; sampled only in IDLE.
REQ-005 SHALL have port op_div  in  1  operation select, sampled with op_start: 0=multiply, 1=divide.
REQ-006 SHALL have ports data_a, data_b  in  32  operands, sampled with op_start.
REQ-007 SHALL have ports hi_we, lo_we  in  1  direct write enables for HI/LO.
REQ-008 SHALL have port wdata  in  32  direct write data.
REQ-009 SHALL have ports md_high, md_low  in  32  result from the multiply/divide unit.
REQ-010 SHALL have port md_zero  in  1  divide-by-zero flag from the multiply/divide unit.
REQ-011 SHALL have ports md_start, md_set  out  1  start and select (1=divide) to the multiply/divide unit.
REQ-012 SHALL have ports md_a, md_b  out  32  registered operands to the multiply/divide unit.
REQ-013 SHALL have ports hi, lo  out  32  architectural HI/LO registers.
REQ-014 SHALL have ports busy, done, div_zero  out  1  status: stall request, completion pulse, divide-by-zero exception pulse.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, CAPTURE, DONE.
- IDLE: op_start=1 -> BUSY.
- BUSY: cnt==MD_CYCLES-1 -> CAPTURE.
- CAPTURE -> DONE.
- DONE -> IDLE.
REQ-016 SHALL, on the edge leaving IDLE, latch data_a->md_a, data_b->md_b, op_div->md_set, clear cnt; md_a, md_b, md_set SHALL hold stable until the next start.
REQ-017 SHALL drive md_start=1 in BUSY and CAPTURE, and 0 in IDLE and DONE.
REQ-018 SHALL increment the 6-bit cnt by 1 per BUSY cycle (0..MD_CYCLES-1), and hold cnt outside BUSY.
REQ-019 SHALL, on the edge leaving CAPTURE, load hi<=md_high and lo<=md_low, unless md_set=1 and md_zero=1.
REQ-020 SHALL, if md_set=1 and md_zero=1 in CAPTURE, leave hi/lo unchanged and assert div_zero for exactly the DONE cycle; div_zero SHALL otherwise be 0, and md_zero SHALL be ignored for multiply.
REQ-021 SHALL assert done=1 for exactly one cycle (DONE state).
- Latency: op_start sampled at edge E -> done high in the cycle after edge E+MD_CYCLES+1 (35 cycles for the default).
- Latency SHALL be identical for multiply and divide.
REQ-022 SHALL drive busy=1 in IDLE when op_start=1, and in BUSY and CAPTURE; busy SHALL be 0 in DONE and in IDLE otherwise.
REQ-023 SHALL apply direct writes (hi_we->hi<=wdata, lo_we->lo<=wdata, both independent) only in IDLE or DONE.
- Writes SHALL be dropped, not queued, in BUSY/CAPTURE.
REQ-024 SHALL, on simultaneous hi_we/lo_we and op_start in IDLE, perform both the write and the start; the later CAPTURE SHALL overwrite hi/lo.
REQ-025 SHALL ignore op_start in BUSY, CAPTURE and DONE; a start is accepted only in IDLE (the cycle after DONE at earliest).
REQ-026 SHALL treat operands as 32-bit two's complement; no width change occurs inside the block.

Reset
REQ-027 SHALL, while reset=0, force immediately (asynchronously) state=IDLE, cnt=0, hi=lo=0, md_a=md_b=0, md_set=0, md_start=0, busy=done=div_zero=0.
REQ-028 SHALL, on reset asserted mid-operation, abandon the operation: no hi/lo update and no done pulse; after release the FSM SHALL accept a new op_start normally.

Verification
REQ-029 Multiply: op_start, op_div=0, a=7, b=-3, model returns {0xFFFFFFFF,0xFFFFFFEB} -> md_start high 34 cycles, done 35 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
REQ-030 Divide: a=100, b=7, model returns high=2, low=14 -> hi=2, lo=14 at done, md_set=1 throughout.
REQ-031 Divide by zero: a=5, b=0, md_zero=1; hi/lo preloaded 0x11/0x22 via hi_we/lo_we -> done and div_zero both pulse one cycle; hi=0x11, lo=0x22 unchanged.
REQ-032 Stall rules: hi_we with wdata=0xABCD at cnt=10 and a second op_start in BUSY -> hi not written, second start ignored; hi_we in DONE cycle -> hi=0xABCD.
REQ-033 Reset mid-op: reset=0 at cnt=20 for 2 cycles -> all outputs 0 immediately, no done; new op_start after release completes with correct latency.
REQ-034 Simultaneous: lo_we (wdata=0x55) with op_start in IDLE -> lo=0x55 next cycle, then overwritten by the result at capture.

Source files
------------

// File: rtl/hilo_md_if.sv
// Handshake and operand/result bundle between the HI/LO controller and the
// multiply/divide unit.
interface hilo_md_if;
  logic        md_start;
  logic        md_set;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_high;
  logic [31:0] md_low;
  logic        md_zero;

  modport master (
    output md_start, md_set, md_a, md_b,
    input  md_high, md_low, md_zero
  );

  modport slave (
    input  md_start, md_set, md_a, md_b,
    output md_high, md_low, md_zero
  );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences a fixed-latency multiply/divide unit,
// captures its result into HI/LO and arbitrates direct register writes.
module hilo_ctrl #(
  parameter int unsigned MD_CYCLES = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_div,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  hilo_md_if.master   md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned DATA_W   = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   md_a_q, md_a_d;
  logic [DATA_W-1:0]   md_b_q, md_b_d;
  logic                md_set_q, md_set_d;
  logic                md_start_q, md_start_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                div_zero_q, div_zero_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      md_a_q     <= '0;
      md_b_q     <= '0;
      md_set_q   <= 1'b0;
      md_start_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_a_q     <= md_a_d;
      md_b_q     <= md_b_d;
      md_set_q   <= md_set_d;
      md_start_q <= md_start_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Next-state, datapath and status decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_a_d     = md_a_q;
    md_b_d     = md_b_q;
    md_set_d   = md_set_q;
    md_start_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy = op_start;
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (op_start) begin
          state_d    = S_BUSY;
          cnt_d      = '0;
          md_a_d     = data_a;
          md_b_d     = data_b;
          md_set_d   = op_div;
          md_start_d = 1'b1;
        end
      end

      S_BUSY: begin
        busy       = 1'b1;
        md_start_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CAPTURE: begin
        busy    = 1'b1;
        state_d = S_DONE;
        done_d  = 1'b1;
        // A zero divisor leaves HI/LO untouched; the flag only matters for divide.
        if (md_set_q && md.md_zero) begin
          div_zero_d = 1'b1;
        end else begin
          hi_d = md.md_high;
          lo_d = md.md_low;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign md.md_start = md_start_q;
  assign md.md_set   = md_set_q;
  assign md.md_a     = md_a_q;
  assign md.md_b     = md_b_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;
  assign div_zero    = div_zero_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: directed operations push expected results,
// a negedge monitor checks them whenever done is presented.
module tb_hilo_ctrl;

  localparam int unsigned MD_CYCLES = 33;
  localparam int unsigned LATENCY   = MD_CYCLES + 1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        set;
    logic [31:0] start_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start, op_div, hi_we, lo_we;
  logic [31:0] data_a, data_b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cyc      = '0;
  int          mds_cnt  = 0;
  exp_t        sb[$];

  hilo_md_if md ();

  hilo_ctrl #(.MD_CYCLES(MD_CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_start (op_start),
    .op_div   (op_div),
    .data_a   (data_a),
    .data_b   (data_b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .md       (md),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (!reset) mds_cnt = 0;
    else if (md.md_start) mds_cnt++;
    if (div_zero && !done) chk("div_zero_without_done", 32'(div_zero), 32'd0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
        chk("sb_div_zero", 32'(div_zero), 32'(e.dz));
        chk("sb_md_set", 32'(md.md_set), 32'(e.set));
        chk("sb_latency", cyc - e.start_cyc, 32'(LATENCY));
        chk("sb_md_start_cycles", 32'(mds_cnt), 32'(LATENCY));
      end
      mds_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic dv,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz);
    exp_t e;
    data_a   = a;
    data_b   = b;
    op_div   = dv;
    op_start = 1'b1;
    #1;
    chk("busy_on_start_req", 32'(busy), 32'd1);
    tick();
    op_start = 1'b0;
    data_a   = 32'h0BAD_0BAD;
    data_b   = 32'h0BAD_0BAD;
    e.hi = eh; e.lo = el; e.dz = edz; e.set = dv; e.start_cyc = cyc;
    sb.push_back(e);
    chk("md_a_latched", md.md_a, a);
    chk("md_b_latched", md.md_b, b);
    chk("md_set_latched", 32'(md.md_set), 32'(dv));
    chk("md_start_busy", 32'(md.md_start), 32'd1);
  endtask

  // Returns in the DONE cycle (#1 after the edge entering it)
  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    else       chk("busy_in_done", 32'(busy), 32'd0);
  endtask

  task automatic set_md(input logic [31:0] h, input logic [31:0] l, input logic z);
    md.md_high = h;
    md.md_low  = l;
    md.md_zero = z;
  endtask

  initial begin
    reset = 1'b0; op_start = 1'b0; op_div = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    data_a = '0; data_b = '0; wdata = '0;
    set_md('0, '0, 1'b0);
    repeat (3) tick();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_md_a", md.md_a, 32'd0);
    chk("rst_md_start", 32'(md.md_start), 32'd0);
    chk("rst_status", 32'({busy, done, div_zero, md.md_set}), 32'd0);
    reset = 1'b1;
    tick();

    // Multiply 7 * -3
    set_md(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    start_op(32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_done();
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);

    // Divide 100 / 7
    set_md(32'd2, 32'd14, 1'b0);
    start_op(32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    wait_done();
    tick();

    // Preload then divide by zero
    hi_we = 1'b1; wdata = 32'h11; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22; tick();
    lo_we = 1'b0;
    chk("preload_hi", hi, 32'h11);
    chk("preload_lo", lo, 32'h22);
    set_md(32'hDEAD_DEAD, 32'hBEEF_BEEF, 1'b1);
    start_op(32'd5, 32'd0, 1'b1, 32'h11, 32'h22, 1'b1);
    wait_done();
    tick();
    chk("div_zero_one_cycle", 32'({done, div_zero}), 32'd0);

    // Stall: write and restart during BUSY are dropped; write in DONE lands
    set_md(32'h1234, 32'h5678, 1'b0);
    start_op(32'd3, 32'd4, 1'b0, 32'h1234, 32'h5678, 1'b0);
    repeat (10) tick();
    hi_we = 1'b1; wdata = 32'hABCD;
    data_a = 32'd99; op_div = 1'b1; op_start = 1'b1;
    tick();
    hi_we = 1'b0; op_start = 1'b0;
    chk("busy_write_dropped", hi, 32'h11);
    chk("busy_start_md_a", md.md_a, 32'd3);
    chk("busy_start_md_set", 32'(md.md_set), 32'd0);
    wait_done();
    hi_we = 1'b1; wdata = 32'hABCD;
    tick();
    hi_we = 1'b0;
    chk("done_write_hi", hi, 32'hABCD);
    chk("done_write_lo_kept", lo, 32'h5678);
    repeat (45) tick();

    // Reset mid-operation
    set_md(32'h7777, 32'h8888, 1'b0);
    start_op(32'd9, 32'd9, 1'b0, 32'h7777, 32'h8888, 1'b0);
    repeat (20) tick();
    reset = 1'b0;
    #1;
    chk("async_rst_md_start", 32'(md.md_start), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_md_a", md.md_a, 32'd0);
    void'(sb.pop_back());
    tick(); tick();
    reset = 1'b1;
    repeat (45) tick();
    chk("abandon_lo", lo, 32'd0);
    set_md(32'h0101, 32'h0202, 1'b0);
    start_op(32'd1, 32'd2, 1'b0, 32'h0101, 32'h0202, 1'b0);
    wait_done();
    tick();

    // Simultaneous lo write and start
    set_md(32'hAAAA_0000, 32'h0000_BBBB, 1'b0);
    lo_we = 1'b1; wdata = 32'h55;
    start_op(32'd6, 32'd6, 1'b0, 32'hAAAA_0000, 32'h0000_BBBB, 1'b0);
    lo_we = 1'b0;
    chk("simul_lo_write", lo, 32'h55);
    wait_done();
    tick();
    repeat (3) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
